// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative radix-4 Booth multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mul_pkg;

    localparam int XLEN   = 32;
    localparam int EXT_W  = XLEN + 2;        // operand after sign/zero extension
    localparam int ACC_W  = XLEN + 4;        // accumulator, room for +/-2A plus sign
    localparam int MREG_W = EXT_W + 1;       // extended multiplier plus Booth guard bit
    localparam int PROD_W = 2 * XLEN;
    localparam int ITER   = XLEN / 2 + 1;    // Booth digits covering the 34-bit operand
    localparam int CNT_W  = $clog2(ITER + 1);

    // One-hot state encodings, in sequence order.
    localparam logic [3:0] ST_IDLE = 4'b0001;
    localparam logic [3:0] ST_INIT = 4'b0010;
    localparam logic [3:0] ST_CALC = 4'b0100;
    localparam logic [3:0] ST_DONE = 4'b1000;

    typedef enum logic [3:0] {
        IDLE = ST_IDLE,
        INIT = ST_INIT,
        CALC = ST_CALC,
        DONE = ST_DONE
    } state_t;

    // Booth digit selected by one multiplier triplet.
    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } booth_digit_t;

    // Radix-4 recoding of (m[i+1], m[i], m[i-1]).
    function automatic booth_digit_t booth_decode(input logic [2:0] trip);
        booth_digit_t d;
        case (trip)
            3'b001, 3'b010: d = POS1;
            3'b011:         d = POS2;
            3'b100:         d = NEG2;
            3'b101, 3'b110: d = NEG1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

    // Widen an operand to EXT_W bits; signed operands replicate their MSB.
    function automatic logic [EXT_W-1:0] extend_op(input logic [XLEN-1:0] v,
                                                   input logic            sgn);
        return {{(EXT_W - XLEN){sgn & v[XLEN-1]}}, v};
    endfunction

endpackage

// File: rtl/booth_multiplier_if.sv
// Start/complete handshake and operand/result bus of the Booth multiplier.
// Latency: n/a (wiring only).
// Backpressure: none; the unit ignores start requests while busy.
interface booth_multiplier_if;
    import mul_pkg::*;

    logic            mul;
    logic            mul_signed;
    logic [XLEN-1:0] x;
    logic [XLEN-1:0] y;
    logic [XLEN-1:0] result_hi;
    logic [XLEN-1:0] result_lo;
    logic            complete;

    // Issue side: drives the request and operands, observes the result.
    modport master (
        output mul,
        output mul_signed,
        output x,
        output y,
        input  result_hi,
        input  result_lo,
        input  complete
    );

    // Multiplier side.
    modport slave (
        input  mul,
        input  mul_signed,
        input  x,
        input  y,
        output result_hi,
        output result_lo,
        output complete
    );

endinterface

// File: rtl/booth_pp_gen.sv
// Radix-4 Booth partial-product generator: triplet + multiplicand -> PP bits and carry-in.
// Latency: combinational.
// Backpressure: none.
module booth_pp_gen
    import mul_pkg::*;
(
    input  logic [2:0]       triplet,
    input  logic [EXT_W-1:0] mcand,
    output logic [ACC_W-1:0] pp,
    output logic             cin
);

    booth_digit_t     digit;
    logic [ACC_W-1:0] a1;
    logic [ACC_W-1:0] a2;

    assign digit = booth_decode(triplet);
    assign a1    = {{2{mcand[EXT_W-1]}}, mcand};
    assign a2    = {mcand[EXT_W-1], mcand, 1'b0};

    // Select +/-A or +/-2A; negatives are inverted here and completed by cin in the adder.
    always_comb begin
        pp  = '0;
        cin = 1'b0;
        case (digit)
            POS1: pp = a1;
            POS2: pp = a2;
            NEG1: begin
                pp  = ~a1;
                cin = 1'b1;
            end
            NEG2: begin
                pp  = ~a2;
                cin = 1'b1;
            end
            default: begin
                pp  = '0;
                cin = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/booth_multiplier.sv
// Iterative radix-4 Booth multiplier, 32x32 -> 64, signed or unsigned operands.
// Latency: fixed 19 cycles from the start edge to the complete strobe (INIT, 17x CALC, DONE).
// Backpressure: mul is only sampled in IDLE; requests while busy are dropped, not queued.
module booth_multiplier
    import mul_pkg::*;
(
    input  logic               mul_clk,
    input  logic               reset,
    booth_multiplier_if.slave  bus
);

    state_t            state;
    state_t            state_nxt;

    logic [XLEN-1:0]   x_q;
    logic [XLEN-1:0]   y_q;
    logic              sgn_q;

    logic [EXT_W-1:0]  mcand;
    logic [ACC_W-1:0]  acc;
    logic [MREG_W-1:0] mreg;
    logic [CNT_W-1:0]  cnt;

    logic [ACC_W-1:0]  pp;
    logic              pp_cin;
    logic [ACC_W-1:0]  sum;
    logic [ACC_W-1:0]  acc_nxt;
    logic [MREG_W-1:0] mreg_nxt;
    logic [PROD_W-1:0] product;
    logic              last_iter;

    logic [XLEN-1:0]   res_hi_q;
    logic [XLEN-1:0]   res_lo_q;
    logic              complete_q;

    booth_pp_gen u_pp_gen (
        .triplet (mreg[2:0]),
        .mcand   (mcand),
        .pp      (pp),
        .cin     (pp_cin)
    );

    // One Booth step: add the partial product, then shift {acc, mreg} right by two.
    assign sum       = acc + pp + ACC_W'(pp_cin);
    assign acc_nxt   = {{2{sum[ACC_W-1]}}, sum[ACC_W-1:2]};
    assign mreg_nxt  = {sum[1:0], mreg[MREG_W-1:2]};
    // After the final shift the low product bits sit in mreg above the guard bit.
    assign product   = {acc_nxt[PROD_W-EXT_W-1:0], mreg_nxt[MREG_W-1:1]};
    assign last_iter = (cnt == CNT_W'(1));

    // State register.
    always_ff @(posedge mul_clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state sequencing: IDLE -> INIT -> CALC (ITER cycles) -> DONE -> IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.mul) state_nxt = INIT;
            INIT:    state_nxt = CALC;
            CALC:    if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, accumulator/multiplier register setup and Booth iteration.
    always_ff @(posedge mul_clk or posedge reset) begin
        if (reset) begin
            x_q   <= '0;
            y_q   <= '0;
            sgn_q <= 1'b0;
            mcand <= '0;
            acc   <= '0;
            mreg  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.mul) begin
                        x_q   <= bus.x;
                        y_q   <= bus.y;
                        sgn_q <= bus.mul_signed;
                    end
                end
                INIT: begin
                    mcand <= extend_op(x_q, sgn_q);
                    acc   <= '0;
                    mreg  <= {extend_op(y_q, sgn_q), 1'b0};
                    cnt   <= CNT_W'(ITER);
                end
                CALC: begin
                    acc  <= acc_nxt;
                    mreg <= mreg_nxt;
                    cnt  <= cnt - CNT_W'(1);
                end
                default: begin
                    cnt <= cnt;
                end
            endcase
        end
    end

    // Result and strobe are registered on the CALC -> DONE edge so both are valid in DONE.
    always_ff @(posedge mul_clk or posedge reset) begin
        if (reset) begin
            res_hi_q   <= '0;
            res_lo_q   <= '0;
            complete_q <= 1'b0;
        end else begin
            complete_q <= (state == CALC) && last_iter;
            if ((state == CALC) && last_iter) begin
                res_hi_q <= product[PROD_W-1:XLEN];
                res_lo_q <= product[XLEN-1:0];
            end
        end
    end

    assign bus.result_hi = res_hi_q;
    assign bus.result_lo = res_lo_q;
    assign bus.complete  = complete_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed and randomized checks of booth_multiplier against a 64-bit arithmetic model.
module tb_booth_multiplier;

    logic mul_clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    // The start edge is edge 0; INIT and 17 CALC cycles follow, so the edge that
    // opens the DONE cycle (complete high) is the 18th edge after the start edge.
    localparam int START_TO_DONE = 18;
    localparam int OP_PERIOD     = 20;

    logic [63:0] last_res;

    booth_multiplier_if bus();

    booth_multiplier dut (
        .mul_clk (mul_clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 mul_clk = ~mul_clk;

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic sg);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] sp;
        if (sg) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            sp = sa * sb;
            return sp;
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // One complete operation: pulse mul, optionally disturb operands mid-CALC, then check
    // latency, result hold before DONE, the product, and that complete lasts one cycle.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sg,
                         input bit scramble, input string tag);
        int          lat;
        bit          held_ok;
        bit          seen;
        logic [63:0] exp;
        exp = ref_mul(a, b, sg);
        @(negedge mul_clk);
        bus.mul        = 1'b1;
        bus.x          = a;
        bus.y          = b;
        bus.mul_signed = sg;
        @(posedge mul_clk);
        #1;
        bus.mul = 1'b0;
        held_ok = 1'b1;
        seen    = 1'b0;
        lat     = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(posedge mul_clk);
            #1;
            if (bus.complete) begin
                seen = 1'b1;
                lat  = k;
            end else if ({bus.result_hi, bus.result_lo} !== last_res) begin
                held_ok = 1'b0;
            end
            if (scramble && k == 5) begin
                bus.x          = $urandom;
                bus.y          = $urandom;
                bus.mul_signed = ~sg;
            end
        end
        check({tag, " latency"}, 64'(lat), 64'(START_TO_DONE));
        check({tag, " hold"}, 64'(held_ok), 64'd1);
        check({tag, " product"}, {bus.result_hi, bus.result_lo}, exp);
        last_res = exp;
        @(posedge mul_clk);
        #1;
        check({tag, " pulse_width"}, 64'(bus.complete), 64'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic [63:0] exp;
        int          pulses[$];
        bit          spurious;
        logic [31:0] corner[6];

        corner[0] = 32'h0000_0000;
        corner[1] = 32'h0000_0001;
        corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000;
        corner[4] = 32'h7FFF_FFFF;
        corner[5] = 32'h5555_5555;

        reset          = 1'b1;
        bus.mul        = 1'b0;
        bus.mul_signed = 1'b0;
        bus.x          = '0;
        bus.y          = '0;
        last_res       = '0;

        // Reset state.
        repeat (2) @(posedge mul_clk);
        #1;
        check("reset result_hi", 64'(bus.result_hi), 64'd0);
        check("reset result_lo", 64'(bus.result_lo), 64'd0);
        check("reset complete", 64'(bus.complete), 64'd0);
        @(negedge mul_clk);
        reset = 1'b0;

        // Directed boundary cases.
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "umax");
        check("umax const", last_res, 64'hFFFF_FFFE_0000_0001);
        do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, "smin_sq");
        check("smin_sq const", last_res, 64'h4000_0000_0000_0000);
        do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, "smin_x1");
        do_op(32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 1'b0, "neg3x7_s");
        do_op(32'hFFFF_FFFD, 32'h0000_0007, 1'b0, 1'b0, "neg3x7_u");
        do_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1, "scramble");

        // Back-to-back with mul held high: pulses every OP_PERIOD edges, one cycle wide.
        exp = ref_mul(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
        @(negedge mul_clk);
        bus.mul        = 1'b1;
        bus.x          = 32'hDEAD_BEEF;
        bus.y          = 32'h0BAD_F00D;
        bus.mul_signed = 1'b1;
        for (int k = 0; k <= 80 && pulses.size() < 3; k++) begin
            @(posedge mul_clk);
            #1;
            if (bus.complete) begin
                pulses.push_back(k);
                check("b2b product", {bus.result_hi, bus.result_lo}, exp);
            end
        end
        bus.mul = 1'b0;
        last_res = exp;
        check("b2b pulse_count", 64'(pulses.size()), 64'd3);
        if (pulses.size() == 3) begin
            check("b2b first", 64'(pulses[0]), 64'(START_TO_DONE));
            check("b2b gap1", 64'(pulses[1] - pulses[0]), 64'(OP_PERIOD));
            check("b2b gap2", 64'(pulses[2] - pulses[1]), 64'(OP_PERIOD));
        end
        @(posedge mul_clk);
        #1;
        check("b2b pulse_width", 64'(bus.complete), 64'd0);

        // Reset during CALC cycle 8: outputs clear at once and no strobe follows.
        @(negedge mul_clk);
        bus.mul        = 1'b1;
        bus.x          = 32'hCAFE_F00D;
        bus.y          = 32'h1357_9BDF;
        bus.mul_signed = 1'b0;
        @(posedge mul_clk);
        #1;
        bus.mul = 1'b0;
        repeat (8) @(posedge mul_clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort result", {bus.result_hi, bus.result_lo}, 64'd0);
        check("abort complete", 64'(bus.complete), 64'd0);
        @(posedge mul_clk);
        @(negedge mul_clk);
        reset    = 1'b0;
        last_res = '0;
        spurious = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge mul_clk);
            #1;
            if (bus.complete) spurious = 1'b1;
        end
        check("abort no_strobe", 64'(spurious), 64'd0);
        do_op(32'd12345, 32'd678, 1'b0, 1'b0, "post_abort");
        check("post_abort const", last_res, 64'd8369910);

        // Randomized regression with a share of corner operands.
        for (int n = 0; n < 2000; n++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) ra = corner[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) rb = corner[$urandom_range(0, 5)];
            do_op(ra, rb, rs, ($urandom_range(0, 3) == 0), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
